// File: rtl/player_health_ctrl.sv
// Player HP, hit acceptance, i-frame window and sprite flash.
// Turns the raw collision level into game state for renderer and game FSM.
module player_health_ctrl #(
    parameter int MAX_HP       = 20,
    parameter int DAMAGE       = 4,
    parameter int IFRAME_TICKS = 60,
    parameter int FLASH_PERIOD = 4
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       collision_detected,
    input  logic       game_start,
    input  logic       heal_req,
    input  logic [6:0] heal_amt,
    output logic [6:0] hp,
    output logic       hit_pulse,
    output logic       invulnerable,
    output logic       player_visible,
    output logic       game_over,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALIVE  = 2'd1,
        INVULN = 2'd2,
        DEAD   = 2'd3
    } state_t;

    localparam logic [7:0] MAX8 = 8'(MAX_HP);
    localparam logic [7:0] DMG8 = 8'(DAMAGE);
    localparam logic [7:0] IFR8 = 8'(IFRAME_TICKS);
    localparam logic [3:0] FP4  = 4'(FLASH_PERIOD);

    state_t     state_q, state_n;
    logic [6:0] hp_n;
    logic       hit_n, inv_n, vis_n, over_n;
    logic [7:0] iframe_q, iframe_n;
    logic [3:0] flash_q, flash_n;

    logic [7:0] hp_sum;
    logic [6:0] healed;
    logic [6:0] h_eff;

    // Heal is saturated before damage so a same-cycle heal can save the player
    assign hp_sum = {1'b0, hp} + {1'b0, heal_amt};
    assign healed = (hp_sum > MAX8) ? MAX8[6:0] : hp_sum[6:0];
    assign h_eff  = heal_req ? healed : hp;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q        <= IDLE;
            hp             <= MAX8[6:0];
            hit_pulse      <= 1'b0;
            invulnerable   <= 1'b0;
            player_visible <= 1'b0;
            game_over      <= 1'b0;
            iframe_q       <= 8'd0;
            flash_q        <= 4'd0;
        end else begin
            state_q        <= state_n;
            hp             <= hp_n;
            hit_pulse      <= hit_n;
            invulnerable   <= inv_n;
            player_visible <= vis_n;
            game_over      <= over_n;
            iframe_q       <= iframe_n;
            flash_q        <= flash_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        hp_n     = hp;
        hit_n    = 1'b0;
        inv_n    = invulnerable;
        vis_n    = player_visible;
        over_n   = game_over;
        iframe_n = iframe_q;
        flash_n  = flash_q;

        if (game_start) begin
            state_n  = ALIVE;
            hp_n     = MAX8[6:0];
            inv_n    = 1'b0;
            vis_n    = 1'b1;
            over_n   = 1'b0;
            iframe_n = 8'd0;
            flash_n  = 4'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    vis_n = 1'b0;
                end
                ALIVE: begin
                    if (collision_detected) begin
                        hit_n = 1'b1;
                        if ({1'b0, h_eff} <= DMG8) begin
                            state_n = DEAD;
                            hp_n    = 7'd0;
                            over_n  = 1'b1;
                            vis_n   = 1'b0;
                            inv_n   = 1'b0;
                        end else begin
                            state_n  = INVULN;
                            hp_n     = h_eff - DMG8[6:0];
                            inv_n    = 1'b1;
                            vis_n    = 1'b0;
                            iframe_n = IFR8;
                            flash_n  = 4'd0;
                        end
                    end else if (heal_req) begin
                        hp_n = healed;
                    end
                end
                INVULN: begin
                    if (heal_req)
                        hp_n = healed;
                    if (frame_tick) begin
                        if (iframe_q == 8'd1) begin
                            state_n  = ALIVE;
                            inv_n    = 1'b0;
                            vis_n    = 1'b1;
                            iframe_n = 8'd0;
                            flash_n  = 4'd0;
                        end else begin
                            iframe_n = iframe_q - 8'd1;
                            if (flash_q + 4'd1 == FP4) begin
                                flash_n = 4'd0;
                                vis_n   = ~player_visible;
                            end else begin
                                flash_n = flash_q + 4'd1;
                            end
                        end
                    end
                end
                DEAD: begin
                    hp_n   = 7'd0;
                    over_n = 1'b1;
                    vis_n  = 1'b0;
                    inv_n  = 1'b0;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_player_health_ctrl.sv
// Directed bench for player_health_ctrl with short i-frame/flash settings.
module tb_player_health_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic       frame_tick = 1'b0;
    logic       collision_detected = 1'b0;
    logic       game_start = 1'b0;
    logic       heal_req = 1'b0;
    logic [6:0] heal_amt = 7'd0;
    logic [6:0] hp;
    logic       hit_pulse;
    logic       invulnerable;
    logic       player_visible;
    logic       game_over;
    logic [1:0] state;

    int n_chk  = 0;
    int n_pass = 0;

    int hits = 0;
    int consec = 0;
    logic prev_hit = 1'b0;
    int hp_seq [5];

    player_health_ctrl #(
        .MAX_HP(20),
        .DAMAGE(4),
        .IFRAME_TICKS(6),
        .FLASH_PERIOD(2)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .resetn(resetn),
        .frame_tick(frame_tick),
        .collision_detected(collision_detected),
        .game_start(game_start),
        .heal_req(heal_req),
        .heal_amt(heal_amt),
        .hp(hp),
        .hit_pulse(hit_pulse),
        .invulnerable(invulnerable),
        .player_visible(player_visible),
        .game_over(game_over),
        .state(state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge CLOCK_50);
        #1;
        if (hit_pulse) begin
            if (hits < 5)
                hp_seq[hits] = int'(hp);
            hits++;
            if (prev_hit)
                consec++;
        end
        prev_hit = hit_pulse;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic start();
        game_start = 1'b1;
        cyc();
        game_start = 1'b0;
    endtask

    task automatic hit_recover();
        collision_detected = 1'b1;
        cyc();
        collision_detected = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        repeat (2) cyc();
        chk("rst_state", state, 0);
        chk("rst_hp", hp, 20);
        chk("rst_vis", player_visible, 0);
        chk("rst_over", game_over, 0);
        chk("rst_inv", invulnerable, 0);
        chk("rst_hit", hit_pulse, 0);
        resetn = 1'b1;

        collision_detected = 1'b1;
        cyc();
        collision_detected = 1'b0;
        tick();
        chk("idle_hp", hp, 20);
        chk("idle_state", state, 0);
        chk("idle_hits", hits, 0);

        start();
        chk("start_state", state, 1);
        chk("start_hp", hp, 20);
        chk("start_vis", player_visible, 1);
        chk("start_over", game_over, 0);

        collision_detected = 1'b1;
        cyc();
        collision_detected = 1'b0;
        chk("hit1_pulse", hit_pulse, 1);
        chk("hit1_hp", hp, 16);
        chk("hit1_inv", invulnerable, 1);
        chk("hit1_state", state, 2);
        chk("hit1_vis", player_visible, 0);
        cyc();
        chk("hit1_pulse_off", hit_pulse, 0);
        tick(); chk("fl_t1", player_visible, 0);
        tick(); chk("fl_t2", player_visible, 1);
        tick(); chk("fl_t3", player_visible, 1);
        tick(); chk("fl_t4", player_visible, 0);
        tick(); chk("fl_t5_state", state, 2);
        tick();
        chk("fl_t6_state", state, 1);
        chk("fl_t6_inv", invulnerable, 0);
        chk("fl_t6_vis", player_visible, 1);

        start();
        hits = 0;
        consec = 0;
        collision_detected = 1'b1;
        cyc();
        repeat (30) tick();
        chk("held_hits", hits, 5);
        chk("held_seq0", hp_seq[0], 16);
        chk("held_seq1", hp_seq[1], 12);
        chk("held_seq2", hp_seq[2], 8);
        chk("held_seq3", hp_seq[3], 4);
        chk("held_seq4", hp_seq[4], 0);
        chk("held_consec", consec, 0);
        chk("held_state", state, 3);
        chk("held_over", game_over, 1);
        chk("held_hp", hp, 0);
        chk("held_vis", player_visible, 0);

        hits = 0;
        game_start = 1'b1;
        cyc();
        game_start = 1'b0;
        collision_detected = 1'b0;
        chk("gs_col_state", state, 1);
        chk("gs_col_hp", hp, 20);
        chk("gs_col_over", game_over, 0);
        cyc();
        chk("gs_col_hits", hits, 0);
        chk("gs_col_hp2", hp, 20);

        repeat (4) hit_recover();
        chk("pre_heal_hp", hp, 4);
        chk("pre_heal_state", state, 1);
        collision_detected = 1'b1;
        heal_req = 1'b1;
        heal_amt = 7'd10;
        cyc();
        collision_detected = 1'b0;
        heal_req = 1'b0;
        chk("hh_hp", hp, 10);
        chk("hh_state", state, 2);
        chk("hh_pulse", hit_pulse, 1);
        heal_req = 1'b1;
        heal_amt = 7'd3;
        cyc();
        chk("inv_heal_hp", hp, 13);
        heal_amt = 7'd100;
        cyc();
        heal_req = 1'b0;
        chk("inv_sat_hp", hp, 20);
        chk("inv_sat_state", state, 2);

        repeat (6) tick();
        repeat (4) hit_recover();
        chk("pre_dead_hp", hp, 4);
        hits = 0;
        collision_detected = 1'b1;
        cyc();
        collision_detected = 1'b0;
        chk("dead_hp", hp, 0);
        chk("dead_state", state, 3);
        chk("dead_pulse", hit_pulse, 1);
        chk("dead_over", game_over, 1);
        cyc();
        chk("dead_pulse_off", hit_pulse, 0);
        chk("dead_hits", hits, 1);

        start();
        collision_detected = 1'b1;
        cyc();
        collision_detected = 1'b0;
        repeat (3) tick();
        chk("mid_state", state, 2);
        resetn = 1'b0;
        cyc();
        chk("mrst_state", state, 0);
        chk("mrst_hp", hp, 20);
        chk("mrst_inv", invulnerable, 0);
        chk("mrst_vis", player_visible, 0);
        resetn = 1'b1;
        repeat (8) tick();
        chk("mrst_ticks_state", state, 0);
        chk("mrst_ticks_hp", hp, 20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
